// File: rtl/fisneg_pipe.sv
// ---------------------------------------------------------------------------
// fisneg_pipe
//   Two-stage handshaked sign classifier for IEEE-754 single-precision
//   operands. Every accepted operand yields exactly one of neg / zero / pos,
//   returned together with the issuer tag. Denormals are treated as zero and
//   inf/NaN are classified by their sign bit alone.
//
//   Stage S1 registers the raw operand and tag. Stage S2 registers the
//   classified flags and tag, which drive the outputs directly.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rstn       synchronous active-low reset
//   in_valid   operand presented
//   in_ready   block can accept an operand this cycle
//   in_op      single-precision operand (sign[31], exp[30:23], frac[22:0])
//   in_tag     tag carried alongside the operand
//   flush      synchronous discard of every in-flight operand
//   out_valid  result presented
//   out_ready  consumer accepts the result this cycle
//   out_neg    operand strictly negative
//   out_zero   operand treated as zero
//   out_pos    operand strictly positive
//   out_tag    tag of the presented result
// ---------------------------------------------------------------------------
module fisneg_pipe #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_neg,
    output logic             out_zero,
    output logic             out_pos,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid;
    logic [31:0]      s1_op;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic             s2_neg;
    logic             s2_zero;
    logic             s2_pos;
    logic [TAG_W-1:0] s2_tag;

    logic             s2_adv;
    logic             in_xfer;
    logic             exp_nz;

    // S2 can take S1's operand when it is empty or its result leaves this cycle.
    assign s2_adv   = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~s1_valid | s2_adv;
    assign in_xfer  = in_valid & in_ready;

    // Any non-zero exponent (including all-ones) is a signed, non-zero value.
    assign exp_nz   = |s1_op[30:23];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_tag   <= in_tag;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Flags are cleared whenever S2 empties so that all flags read 0
    // while out_valid is low.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_neg   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_pos   <= 1'b0;
            s2_tag   <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
            s2_neg   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_pos   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= 1'b1;
            s2_neg   <= s1_op[31] & exp_nz;
            s2_zero  <= ~exp_nz;
            s2_pos   <= ~s1_op[31] & exp_nz;
            s2_tag   <= s1_tag;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
            s2_neg   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_pos   <= 1'b0;
        end
    end

    assign out_valid = s2_valid;
    assign out_neg   = s2_neg;
    assign out_zero  = s2_zero;
    assign out_pos   = s2_pos;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_fisneg_pipe.sv
module tb_fisneg_pipe;

    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_op;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             out_neg;
    logic             out_zero;
    logic             out_pos;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;

    // reference queue entries: {tag, neg, zero, pos}
    logic [TAG_W+2:0] ref_q[$];
    logic             prev_stall = 1'b0;
    logic [TAG_W+3:0] prev_out;

    fisneg_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_neg   (out_neg),
        .out_zero  (out_zero),
        .out_pos   (out_pos),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sign classification straight from the number format: a zero exponent
    // is zero (denormals included), anything else takes the sign bit.
    function automatic logic [2:0] ref_flags(input logic [31:0] op);
        if (op[30:23] == 8'd0) return 3'b010;
        return op[31] ? 3'b100 : 3'b001;
    endfunction

    // Scoreboard: sampled mid-cycle, reflects what the next rising edge does.
    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            ref_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stable", {60'd0, out_valid, out_tag, out_neg, out_zero, out_pos},
                              {54'd0, prev_out});
            if (out_valid) begin
                chk("onehot", 64'({out_neg, out_zero, out_pos} == 3'b100 ||
                                  {out_neg, out_zero, out_pos} == 3'b010 ||
                                  {out_neg, out_zero, out_pos} == 3'b001), 64'd1);
                if (out_ready) begin
                    if (ref_q.size() == 0) chk("dup_result", 64'd1, 64'd0);
                    else chk("result", {55'd0, out_tag, out_neg, out_zero, out_pos},
                                       {55'd0, ref_q.pop_front()});
                end
            end else begin
                chk("idle_flags", {61'd0, out_neg, out_zero, out_pos}, 64'd0);
            end
            prev_stall = out_valid & ~out_ready & ~flush;
            prev_out   = {out_valid, out_tag, out_neg, out_zero, out_pos};
            if (flush) ref_q.delete();
            else if (in_valid && in_ready) begin
                ref_q.push_back({in_tag, ref_flags(in_op)});
                n_acc++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] op, input int tag);
        in_valid = 1'b1;
        in_op    = op;
        in_tag   = TAG_W'(tag);
    endtask

    logic [31:0] stream_op[5];
    logic [31:0] rop;
    int          guard;

    initial begin
        stream_op[0] = 32'hBF800000;
        stream_op[1] = 32'h3F800000;
        stream_op[2] = 32'h80000001;
        stream_op[3] = 32'hFF800000;
        stream_op[4] = 32'h7FC00000;

        rstn = 1'b0; in_valid = 1'b0; in_op = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b0;
        cyc(); cyc();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flags", {61'd0, out_neg, out_zero, out_pos}, 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rstn = 1'b1;

        // single zero operand, latency 2
        out_ready = 1'b1;
        present(32'h00000000, 5);
        cyc();
        in_valid = 1'b0;
        chk("lat_s1_only", 64'(out_valid), 64'd0);
        cyc();
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_flags", {61'd0, out_neg, out_zero, out_pos}, 64'b010);
        chk("lat_tag", 64'(out_tag), 64'd5);
        cyc();
        chk("lat_gone", 64'(out_valid), 64'd0);

        // back-to-back stream, no bubbles
        for (int k = 0; k < 7; k++) begin
            if (k < 5) present(stream_op[k], k + 1);
            else in_valid = 1'b0;
            if (k < 5) chk("stream_in_ready", 64'(in_ready), 64'd1);
            cyc();
            if (k >= 1 && k <= 5) begin
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk("stream_flags", {61'd0, out_neg, out_zero, out_pos},
                    64'(ref_flags(stream_op[k-1])));
                chk("stream_tag", 64'(out_tag), 64'(k));
            end
        end

        // stall: two operands fit, third waits for release
        out_ready = 1'b0;
        present(32'hC1200000, 10);
        cyc();
        present(32'h00400000, 11);
        chk("stall_in_ready2", 64'(in_ready), 64'd1);
        cyc();
        present(32'h41200000, 12);
        chk("stall_full", 64'(in_ready), 64'd0);
        cyc();
        chk("stall_still_full", 64'(in_ready), 64'd0);
        chk("stall_head_tag", 64'(out_tag), 64'd10);
        chk("stall_head_neg", 64'(out_neg), 64'd1);
        out_ready = 1'b1;
        #1;
        chk("release_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        chk("drain_tag11", 64'(out_tag), 64'd11);
        chk("drain_zero", 64'(out_zero), 64'd1);
        cyc();
        chk("drain_tag12", 64'(out_tag), 64'd12);
        chk("drain_pos", 64'(out_pos), 64'd1);
        cyc();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // flush with both stages full and an input offered
        out_ready = 1'b0;
        present(32'hBF800000, 20); cyc();
        present(32'h3F800000, 21); cyc();
        present(32'h3F800000, 22);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        cyc();
        chk("flush_no_ghost", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        present(32'hC0000000, 23); cyc();
        in_valid = 1'b0; cyc();
        chk("post_flush_valid", 64'(out_valid), 64'd1);
        chk("post_flush_neg", 64'(out_neg), 64'd1);
        chk("post_flush_tag", 64'(out_tag), 64'd23);
        cyc();

        // reset beats flush and handshakes
        out_ready = 1'b0;
        present(32'hBF800000, 40); cyc();
        present(32'h3F800000, 41); cyc();
        present(32'h3F800000, 42);
        flush = 1'b1; rstn = 1'b0;
        cyc();
        rstn = 1'b1; flush = 1'b0; in_valid = 1'b0;
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_flags", {61'd0, out_neg, out_zero, out_pos}, 64'd0);
        chk("rst2_tag", 64'(out_tag), 64'd0);
        chk("rst2_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        present(32'h80000000, 30); cyc();
        in_valid = 1'b0;
        chk("rst2_lat1", 64'(out_valid), 64'd0);
        cyc();
        chk("rst2_lat2", 64'(out_valid), 64'd1);
        chk("rst2_zero", 64'(out_zero), 64'd1);
        chk("rst2_tag30", 64'(out_tag), 64'd30);
        cyc();

        // randomized traffic against the scoreboard
        n_acc = 0;
        guard = 0;
        while (n_acc < 10000 && guard < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            rop = $urandom();
            case ($urandom_range(0, 3))
                0: rop[30:23] = 8'h00;
                1: rop[30:23] = 8'hFF;
                default: ;
            endcase
            in_op  = rop;
            in_tag = TAG_W'($urandom());
            cyc();
            guard++;
        end
        chk("random_budget", 64'(n_acc >= 10000), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("random_no_loss", 64'(ref_q.size()), 64'd0);
        chk("random_idle", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
